// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SPI mode, SCLK divider, bit order,
// multiple active-low chip selects with optional hold across words, and internal loopback.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cs_hold,
    input  logic              loopback,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              tx_ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_LAG,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CS_W-1:0]     sel_q, sel_d;
    logic [1:0]          mode_q, mode_d;
    logic                lsb_q, lsb_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                hold_q, hold_d;
    logic                lb_q, lb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;

    logic                miso_eff;
    logic                edge_go;
    logic                lead_edge;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   rx_shift;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        cs_decode = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        div_d      = div_q;
        hold_d     = hold_q;
        lb_d       = lb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        edge_go    = 1'b0;
        lead_edge  = 1'b0;

        miso_eff = lb_q ? mosi_q : miso;
        tx_shift = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        rx_shift = lsb_q ? {miso_eff, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso_eff};

        unique case (state_q)
            S_IDLE: begin
                sclk_d     = mode[1];
                tx_ready_d = 1'b1;
                if (start) begin
                    sel_d      = cs_sel;
                    mode_d     = mode;
                    lsb_d      = lsb_first;
                    div_d      = clk_div;
                    hold_d     = cs_hold;
                    lb_d       = loopback;
                    tx_sr_d    = tx_data;
                    rx_sr_d    = '0;
                    mosi_d     = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                    cnt_d      = '0;
                    // Decoding the new select here also drops a previously held CS.
                    cs_n_d     = cs_decode(cs_sel);
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    state_d    = S_LEAD;
                end
            end
            S_LEAD: begin
                if (cnt_q == div_q) begin
                    cnt_d     = '0;
                    edge_d    = '0;
                    edge_go   = 1'b1;
                    lead_edge = 1'b1;
                    state_d   = S_XFER;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (edge_q == LAST_EDGE) begin
                        state_d = S_LAG;
                    end else begin
                        edge_d    = edge_q + EW'(1);
                        edge_go   = 1'b1;
                        lead_edge = edge_q[0];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_LAG: begin
                if (cnt_q == div_q) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    if (!hold_q) cs_n_d = '1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                sclk_d     = mode[1];
                tx_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Sampling edge is leading for CPHA=0 and trailing for CPHA=1; the other edge shifts.
        if (edge_go) begin
            sclk_d = ~sclk_q;
            if (lead_edge ^ mode_q[0]) begin
                rx_sr_d = rx_shift;
            end else if (mode_q[0]) begin
                mosi_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
                tx_sr_d = tx_shift;
            end else begin
                mosi_d  = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
                tx_sr_d = tx_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sel_q      <= '0;
            mode_q     <= '0;
            lsb_q      <= 1'b0;
            div_q      <= '0;
            hold_q     <= 1'b0;
            lb_q       <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            div_q      <= div_d;
            hold_q     <= hold_d;
            lb_q       <= lb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: directed scenarios plus randomized transfers
// compared against a word-level reference (slave model, CS bookkeeping, cycle arithmetic).
module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic [1:0] cs_sel;
    logic [1:0] mode;
    logic       lsb_first;
    logic [7:0] clk_div;
    logic       cs_hold;
    logic       loopback;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic [2:0] cs_n;
    logic       tx_ready;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [2:0]  held_cs = 3'b111;
    logic        slv_on = 1'b0;
    logic [7:0]  slv_word = '0;
    logic        slv_lsb = 1'b0;
    logic        slv_cpha = 1'b0;
    logic        slv_prev = 1'b0;
    int unsigned slv_e = 0;

    spi_master_param #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
        .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div), .cs_hold(cs_hold),
        .loopback(loopback), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .tx_ready(tx_ready), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cs_dec(input logic [1:0] s);
        logic [2:0] r;
        r = 3'b111;
        if (s < 2'd3) r[s] = 1'b0;
        return r;
    endfunction

    function automatic logic slv_bit(input int unsigned i);
        if (i >= 8) return 1'b0;
        return slv_lsb ? slv_word[i] : slv_word[7-i];
    endfunction

    // Slave: updates miso after each SCLK shift edge, well before the next sampling edge.
    always @(negedge clk) begin
        if (slv_on && sclk !== slv_prev) begin
            slv_prev = sclk;
            slv_e++;
            if (slv_cpha && (slv_e % 2 == 1)) miso = slv_bit((slv_e - 1) / 2);
            else if (!slv_cpha && (slv_e % 2 == 0)) miso = slv_bit(slv_e / 2);
        end
    end

    task automatic do_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic [1:0] md,
                           input logic lsb, input logic [7:0] div, input logic hold,
                           input logic lb, input logic [7:0] sw, input logic pulse);
        logic [7:0]  got_mosi;
        logic [2:0]  exp_cs;
        logic [7:0]  exp_rx;
        logic        last;
        int unsigned edges, done_cyc, cs_bad, h, k;
        got_mosi = '0;
        edges = 0;
        done_cyc = 0;
        cs_bad = 0;
        h = int'(div) + 1;
        exp_cs = cs_dec(sel);
        exp_rx = lb ? tx : sw;

        @(negedge clk);
        tx_data = tx; cs_sel = sel; mode = md; lsb_first = lsb;
        clk_div = div; cs_hold = hold; loopback = lb;
        @(negedge clk);
        check("idle_sclk", 32'(sclk), 32'(md[1]));
        check("idle_cs", 32'(cs_n), 32'(held_cs));
        check("idle_ready", 32'(tx_ready), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        slv_word = sw; slv_lsb = lsb; slv_cpha = md[0]; slv_prev = md[1]; slv_e = 0;
        miso = slv_bit(0);
        slv_on = 1'b1;
        last = md[1];

        for (int unsigned cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (pulse && (cyc == 5 || cyc == 10)) begin
                start = 1'b1;
                tx_data = ~tx;
            end else begin
                start = 1'b0;
            end
            if (rx_valid) begin
                done_cyc = cyc;
                break;
            end
            if (sclk !== last) begin
                last = sclk;
                edges++;
                if (edges % 2 == 1) begin
                    k = (edges - 1) / 2;
                    if (k < 8) begin
                        if (lsb) got_mosi[k] = mosi;
                        else got_mosi[7-k] = mosi;
                    end
                end
            end
            if (cs_n !== exp_cs) cs_bad++;
        end
        start = 1'b0;
        slv_on = 1'b0;

        check("rx_cycle", done_cyc, (2 * 8 + 2) * h + 1);
        check("rx_data", 32'(rx_data), 32'(exp_rx));
        check("sclk_edges", edges, 32'd16);
        check("mosi_bits", 32'(got_mosi), 32'(tx));
        check("cs_during", cs_bad, 32'd0);
        check("cs_done", 32'(cs_n), 32'(hold ? exp_cs : 3'b111));
        check("busy_done", 32'(busy), 32'd0);
        held_cs = hold ? exp_cs : 3'b111;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned pulses;
        reset = 1'b1; start = 1'b0; tx_data = '0; cs_sel = '0; mode = '0;
        lsb_first = 1'b0; clk_div = '0; cs_hold = 1'b0; loopback = 1'b0; miso = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(cs_n), 32'h7);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_rxv", 32'(rx_valid), 32'd0);
        check("rst_rxd", 32'(rx_data), 32'd0);
        reset = 1'b0;

        // Mode 0 loopback, fastest clock.
        do_xfer(8'hA5, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        // Mode 3 with external slave on cs1.
        do_xfer(8'h81, 2'd1, 2'd3, 1'b0, 8'd3, 1'b0, 1'b0, 8'h3C, 1'b0);
        // LSB-first loopback in modes 1 and 2.
        do_xfer(8'h01, 2'd0, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        do_xfer(8'h80, 2'd0, 2'd2, 1'b1, 8'd1, 1'b0, 1'b1, 8'h00, 1'b0);
        // CS hold across words to the same slave, then switching slave.
        do_xfer(8'h12, 2'd0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b1, 8'h00, 1'b0);
        do_xfer(8'h34, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        do_xfer(8'h56, 2'd0, 2'd1, 1'b0, 8'd0, 1'b1, 1'b1, 8'h00, 1'b0);
        do_xfer(8'h78, 2'd1, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        // Out-of-range select: no CS asserted.
        do_xfer(8'h5A, 2'd3, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Starts during a transfer are ignored.
        do_xfer(8'hC3, 2'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
        end
        check("no_extra_rxv", pulses, 32'd0);
        check("ready_after", 32'(tx_ready), 32'd1);

        // Reset in the middle of a transfer.
        @(negedge clk);
        tx_data = 8'h66; cs_sel = 2'd0; mode = 2'd1; lsb_first = 1'b0;
        clk_div = 8'd0; cs_hold = 1'b1; loopback = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_cs", 32'(cs_n), 32'h7);
        check("mrst_sclk", 32'(sclk), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_rxv", 32'(rx_valid), 32'd0);
        check("mrst_rxd", 32'(rx_data), 32'd0);
        check("mrst_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        mode = 2'd0;
        held_cs = 3'b111;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
        end
        check("mrst_no_rxv", pulses, 32'd0);

        // Randomized transfers.
        for (int n = 0; n < 30; n++) begin
            do_xfer(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
